// File: rtl/mux2_pkg.sv
// ---------------------------------------------------------------------------
// mux2_pkg : shared definitions for the registered 2:1 multiplexer
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package mux2_pkg;

  // Default operand width and the largest width the block supports.
  localparam int MUX2_DEFAULT_WIDTH = 8;
  localparam int MUX2_MAX_WIDTH     = 1024;

  // Select encoding: a value of 1 picks operand b, anything else picks a.
  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } mux2_sel_e;

  // Even parity (XOR of all bits). Operands narrower than the maximum are
  // zero-extended by the caller, which leaves the parity unchanged.
  function automatic logic mux2_parity(input logic [MUX2_MAX_WIDTH-1:0] v);
    return ^v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux2_sel.sv
// ---------------------------------------------------------------------------
// mux2_sel : purely combinational WIDTH-bit 2:1 selector
//            (a when c is not 1, b when c is 1)
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mux2_sel
  import mux2_pkg::*;
#(
  parameter int WIDTH = MUX2_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sel_d
);

  mux2_sel_e sel;

  assign sel = mux2_sel_e'(c);

  // Pick b only on an explicit 1; X/Z in simulation fall to the default (a).
  always_comb begin
    sel_d = a;
    case (sel)
      SEL_B:   sel_d = b;
      default: sel_d = a;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mux2.sv
// ---------------------------------------------------------------------------
// mux2     : registered, parameterised 2:1 data multiplexer with a valid
//            qualifier. Output y is loaded from the selected operand on
//            every valid cycle and held otherwise; out_vld is a one-cycle
//            delayed copy of in_vld.
//            Optional feature macro: MUX2_PARITY_EN adds a registered even
//            parity output y_par that always equals ^y.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mux2
  import mux2_pkg::*;
#(
  parameter int WIDTH = MUX2_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_vld,
  output logic [WIDTH-1:0] y,
  output logic             out_vld
`ifdef MUX2_PARITY_EN
  ,
  output logic             y_par
`endif
);

  logic [WIDTH-1:0] sel_d;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  logic             out_vld_d;
  logic             out_vld_q;

  mux2_sel #(
    .WIDTH (WIDTH)
  ) u_sel (
    .a     (a),
    .b     (b),
    .c     (c),
    .sel_d (sel_d)
  );

  // Load the selected operand on valid cycles, otherwise hold.
  always_comb begin
    y_d       = y_q;
    out_vld_d = in_vld;
    if (in_vld) begin
      y_d = sel_d;
    end
  end

  // Output and valid registers; reset wins over any incoming valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q       <= '0;
      out_vld_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign y       = y_q;
  assign out_vld = out_vld_q;

`ifdef MUX2_PARITY_EN
  logic [MUX2_MAX_WIDTH-1:0] sel_ext;
  logic                      y_par_d;
  logic                      y_par_q;

  // Parity is taken from the same operand that loads y, so it tracks ^y.
  always_comb begin
    sel_ext              = '0;
    sel_ext[WIDTH-1:0]   = sel_d;
    y_par_d              = y_par_q;
    if (in_vld) begin
      y_par_d = mux2_parity(sel_ext);
    end
  end

  // Parity register, loaded in lockstep with y.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_par_q <= 1'b0;
    end else begin
      y_par_q <= y_par_d;
    end
  end

  assign y_par = y_par_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux2.sv
// ---------------------------------------------------------------------------
// tb_mux2  : self-checking bench for mux2 (WIDTH = 8)
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mux2;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c;
  logic         in_vld;
  logic [W-1:0] y;
  logic         out_vld;
`ifdef MUX2_PARITY_EN
  logic         y_par;
`endif

  int total = 0;
  int bad   = 0;

  // Reference state: what y / out_vld must be after the latest edge.
  logic [W-1:0] m_y;
  logic         m_vld;
  bit           m_known = 1'b0;

  mux2 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .c       (c),
    .in_vld  (in_vld),
    .y       (y),
    .out_vld (out_vld)
`ifdef MUX2_PARITY_EN
    ,
    .y_par   (y_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: reset clears, valid loads the chosen operand, idle holds.
  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      m_y     = '0;
      m_vld   = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (in_vld === 1'b1) begin
        m_y   = (c === 1'b1) ? b : a;
        m_vld = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      check("model_y", y, m_y);
      check("model_vld", {7'b0, out_vld}, {7'b0, m_vld});
`ifdef MUX2_PARITY_EN
      check("model_par", {7'b0, y_par}, {7'b0, ^m_y});
`endif
    end
  end

  // Apply one set of inputs, then wait for the edge that consumes them.
  task automatic step(input logic r, input logic v, input logic [W-1:0] ia,
                      input logic [W-1:0] ib, input logic ic);
    rst_n  = r;
    in_vld = v;
    a      = ia;
    b      = ib;
    c      = ic;
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] ey, input logic ev);
    check({name, "_y"}, y, ey);
    check({name, "_vld"}, {7'b0, out_vld}, {7'b0, ev});
  endtask

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; a = '0; b = '0; c = 1'b0;
    @(negedge clk);

    // Reset held with valid input pending: outputs stay cleared.
    step(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
    expect_out("rst1", 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
    expect_out("rst2", 8'h00, 1'b0);
`ifdef MUX2_PARITY_EN
    check("rst_par", {7'b0, y_par}, 8'h00);
`endif
    step(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0);
    expect_out("rel", 8'hFF, 1'b1);

    // Select a, then b.
    step(1'b1, 1'b1, 8'h19, 8'h2A, 1'b0);
    expect_out("sel_a", 8'h19, 1'b1);
`ifdef MUX2_PARITY_EN
    check("par_19", {7'b0, y_par}, 8'h01);
`endif
    step(1'b1, 1'b1, 8'h19, 8'h2A, 1'b1);
    expect_out("sel_b", 8'h2A, 1'b1);
`ifdef MUX2_PARITY_EN
    check("par_2a", {7'b0, y_par}, 8'h01);
`endif

    // Idle cycles with changing c/a: y holds.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'h55, 8'h2A, i[0]);
      expect_out("hold", 8'h2A, 1'b0);
    end

    step(1'b1, 1'b1, 8'h03, 8'hC0, 1'b0);
    expect_out("sel_03", 8'h03, 1'b1);
`ifdef MUX2_PARITY_EN
    check("par_03", {7'b0, y_par}, 8'h00);
`endif

    // Full-scale operand values pass bit-for-bit.
    step(1'b1, 1'b1, 8'h00, 8'hFF, 1'b1);
    expect_out("ones", 8'hFF, 1'b1);
    step(1'b1, 1'b1, 8'h80, 8'h01, 1'b0);
    expect_out("msb", 8'h80, 1'b1);

    // Non-1 select value must pick a.
    step(1'b1, 1'b1, 8'h6C, 8'h93, 1'bx);
    expect_out("sel_x", 8'h6C, 1'b1);

    // Alternating stream, then reset mid-stream.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 8'h11 + 8'(i), 8'hE0 + 8'(i), i[0]);
      expect_out("stream", i[0] ? (8'hE0 + 8'(i)) : (8'h11 + 8'(i)), 1'b1);
    end
    step(1'b0, 1'b1, 8'h77, 8'h88, 1'b1);
    expect_out("mid_rst", 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h5A, 8'hA5, 1'b0);
    expect_out("resume", 8'h5A, 1'b1);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    expect_out("idle_end", 8'h5A, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
